pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020: exception handler entry PC.
REQ-002 Parameter STALL_TIMEOUT, default 1024: consecutive-stall cycle count that flags a hang.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stallreq_if  input  1  fetch stage wait request, e.g. instruction bus not ready.
REQ-006 stallreq_id  input  1  decode stage request, e.g. load-use hazard.
REQ-007 stallreq_ex  input  1  execute stage request, e.g. multi-cycle mul/div busy.
REQ-008 stallreq_mem  input  1  memory stage request, e.g. data bus not ready.
REQ-009 excepttype  input  32  MEM-stage exception code; 0 means none.
REQ-010 cp0_epc  input  32  EPC value from CP0, used on ERET.
REQ-011 stall  output  6  per-stage hold; bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 means stop.
REQ-012 flush  output  1  one-cycle pipeline flush pulse.
REQ-013 new_pc  output  32  redirect PC, valid while flush=1.
REQ-014 stall_timeout  output  1  sticky hang flag.
REQ-015 stall_cycles  output  32  saturating count of cycles with stall!=0.
REQ-016 flush_count  output  16  saturating count of flush pulses.

Function
REQ-017 FSM states: RUN, EXC_HOLD, FLUSH.
REQ-018 RUN, excepttype==0: stall is combinational from the requests; the highest requesting stage wins.
- mem gives 6'b011111.
- ex gives 6'b001111.
- id gives 6'b000111.
- if gives 6'b000011.
- none gives 6'b000000.
REQ-019 RUN, excepttype!=0, any request state: same cycle stall=6'b111111. Next state EXC_HOLD. Latch the target:
- excepttype==32'h0000_000e (ERET): new_pc target = cp0_epc.
- any other nonzero code: new_pc target = EXC_VECTOR.
REQ-020 EXC_HOLD lasts 1 cycle: stall=6'b000000, flush=1, new_pc=latched target. Next state FLUSH.
REQ-021 FLUSH lasts 1 cycle: stall=6'b000000, flush=0. excepttype and all stall requests are ignored. Next state RUN.
REQ-022 flush is registered and asserted only in EXC_HOLD; it is never high for 2 consecutive cycles.
REQ-023 new_pc holds its last latched value when flush=0; reset value 0.
REQ-024 A second exception is accepted only from RUN; codes presented in EXC_HOLD or FLUSH are dropped.
REQ-025 Consecutive-stall counter (16-bit):
- increments each cycle stall!=0;
- clears in any cycle stall==0;
- saturates at 16'hFFFF.
REQ-026 stall_timeout sets when the counter reaches STALL_TIMEOUT. It stays set until rst.
REQ-027 stall_cycles increments every cycle stall!=0, including the exception detect cycle. It saturates at 32'hFFFF_FFFF.
REQ-028 flush_count increments once per flush pulse and saturates at 16'hFFFF.
REQ-029 Requests asserted while stall is already active update the vector the same cycle. There is no minimum stall length.

Reset
REQ-030 rst takes priority over all inputs, including a pending exception. It forces:
- state=RUN, stall=0, flush=0, new_pc=0;
- stall_timeout=0, stall_cycles=0, flush_count=0, consecutive counter=0.
REQ-031 rst asserted in EXC_HOLD cancels the pending flush. The first post-reset cycle has flush=0.
REQ-032 In the first cycle after rst deasserts, stall follows the RUN mapping of the current requests.

Verification
REQ-033 Priority: stallreq_id=1 and stallreq_mem=1 in the same cycle -> stall=6'b011111. Then drop mem -> stall=6'b000111 the same cycle.
REQ-034 Exception:
- stimulus: excepttype=32'h0000_000c at cycle N;
- cycle N: stall=6'b111111;
- cycle N+1: flush=1, new_pc=32'h0000_0020;
- cycle N+2: flush=0, stall=0 even with stallreq_ex=1;
- cycle N+3: stall=6'b001111;
- flush_count=1.
REQ-035 ERET: cp0_epc=32'h8000_1234 and excepttype=32'h0000_000e at N -> cycle N+1: flush=1, new_pc=32'h8000_1234. Change cp0_epc at N+1 -> new_pc unchanged.
REQ-036 Watchdog: hold stallreq_ex=1 for 1024 cycles -> stall_timeout rises on the 1024th stalled cycle and stays 1 after the request drops. stall_cycles=1024.
REQ-037 Reset mid-exception: exception at N, rst=1 at N+1 -> at N+2 flush=0, new_pc=0, flush_count=0, stall=0.
REQ-038 Back-to-back: excepttype nonzero for 3 cycles N..N+2 -> exactly one flush pulse, at N+1. A new exception is detected at N+3 if excepttype is still nonzero.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall generation, exception flush sequencing
// (RUN -> EXC_HOLD -> FLUSH), a stall watchdog and saturating activity counters.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic [1:0] {RUN, EXC_HOLD, FLUSH} state_e;

  localparam logic [31:0] ERET_CODE = 32'h0000_000e;

  state_e      state_q, state_d;
  logic        flush_q, flush_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic [15:0] consec_q, consec_d;
  logic        timeout_q, timeout_d;
  logic [31:0] cycles_q, cycles_d;
  logic [15:0] fcount_q, fcount_d;

  always_comb begin
    state_d  = state_q;
    flush_d  = 1'b0;
    new_pc_d = new_pc_q;
    stall    = '0;
    case (state_q)
      RUN: begin
        if (excepttype != '0) begin
          stall    = '1;
          state_d  = EXC_HOLD;
          flush_d  = 1'b1;
          new_pc_d = (excepttype == ERET_CODE) ? cp0_epc : EXC_VECTOR;
        end else if (stallreq_mem) begin
          stall = 6'b011111;
        end else if (stallreq_ex) begin
          stall = 6'b001111;
        end else if (stallreq_id) begin
          stall = 6'b000111;
        end else if (stallreq_if) begin
          stall = 6'b000011;
        end
      end
      EXC_HOLD: state_d = FLUSH;
      FLUSH:    state_d = RUN;
      default:  state_d = RUN;
    endcase
    // Reset masks the combinational stall too, so a pending exception never leaks out.
    if (rst) stall = '0;
  end

  always_comb begin
    consec_d = '0;
    cycles_d = cycles_q;
    if (stall != '0) begin
      consec_d = (&consec_q) ? consec_q : consec_q + 16'd1;
      cycles_d = (&cycles_q) ? cycles_q : cycles_q + 32'd1;
    end
    timeout_d = timeout_q | (32'(consec_d) == STALL_TIMEOUT);
    fcount_d  = (flush_q && !(&fcount_q)) ? fcount_q + 16'd1 : fcount_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      flush_q   <= 1'b0;
      new_pc_q  <= '0;
      consec_q  <= '0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      fcount_q  <= '0;
    end else begin
      state_q   <= state_d;
      flush_q   <= flush_d;
      new_pc_q  <= new_pc_d;
      consec_q  <= consec_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      fcount_q  <= fcount_d;
    end
  end

  assign flush         = flush_q;
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign stall_cycles  = cycles_q;
  assign flush_count   = fcount_q;

endmodule
